// File: rtl/passcode_checker_pkg.sv
// Shared definitions for the passcode checker: controller state encoding and BCD limits.
package passcode_checker_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [2:0] NUM_DIGITS = 3'd4;

endpackage

// File: rtl/passcode_entry_buffer.sv
// Collects keyed BCD digits into a 4-digit shift buffer; the first digit keyed ends up most significant.
module passcode_entry_buffer
    import passcode_checker_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        consume_i,
    input  logic        key_valid_i,
    input  logic [3:0]  key_digit_i,
    input  logic        key_clear_i,
    output logic [15:0] buffer_o,
    output logic [2:0]  digit_count_o,
    output logic        full_o
);

    logic [15:0] buffer_q, buffer_d;
    logic [2:0]  count_q, count_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        buffer_d = buffer_q;
        count_d  = count_q;
        if (consume_i) begin
            buffer_d = '0;
            count_d  = '0;
        end else if (enable_i) begin
            if (key_clear_i) begin
                buffer_d = '0;
                count_d  = '0;
            end else if (key_valid_i && (key_digit_i <= BCD_MAX) && (count_q < NUM_DIGITS)) begin
                buffer_d = {buffer_q[11:0], key_digit_i};
                count_d  = count_q + 3'd1;
            end
        end
    end

    // Flags the edge on which the final digit lands, so the controller enters CHECK on that same edge.
    assign full_o        = (count_d == NUM_DIGITS);
    assign buffer_o      = buffer_q;
    assign digit_count_o = count_q;

endmodule

// File: rtl/passcode_checker.sv
// Compares a keyed 4-digit entry against the stored passcode, driving a timed unlock or a timed alarm lockout.
module passcode_checker
    import passcode_checker_pkg::*;
#(
    parameter int UNLOCK_CYCLES  = 50,
    parameter int LOCKOUT_CYCLES = 200,
    parameter int MAX_FAIL       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] code4,
    input  logic [3:0] code3,
    input  logic [3:0] code2,
    input  logic [3:0] code1,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] digit_count,
    output logic [3:0] fail_count,
    output logic       match_pulse,
    output logic       fail_pulse
);

    localparam int MAX_CYCLES = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
    localparam logic [3:0]         FAIL_LIMIT   = 4'(MAX_FAIL);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 unlock_q, unlock_d;
    logic                 alarm_q, alarm_d;
    logic [3:0]           fail_count_q, fail_count_d;
    logic                 match_q, match_d;
    logic                 fail_pulse_q, fail_pulse_d;
    logic [15:0]          entry;
    logic                 entryFull;
    logic                 codeMatch;

    passcode_entry_buffer u_entry_buffer (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (state_q == ENTRY),
        .consume_i     (state_q == CHECK),
        .key_valid_i   (key_valid),
        .key_digit_i   (key_digit),
        .key_clear_i   (key_clear),
        .buffer_o      (entry),
        .digit_count_o (digit_count),
        .full_o        (entryFull)
    );

    // Stored digits are sampled live during CHECK only; the verdict is latched into the registers below.
    assign codeMatch = (entry == {code4, code3, code2, code1});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ENTRY;
            timer_q      <= '0;
            unlock_q     <= 1'b0;
            alarm_q      <= 1'b0;
            fail_count_q <= '0;
            match_q      <= 1'b0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            unlock_q     <= unlock_d;
            alarm_q      <= alarm_d;
            fail_count_q <= fail_count_d;
            match_q      <= match_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        unlock_d     = unlock_q;
        alarm_d      = alarm_q;
        fail_count_d = fail_count_q;
        match_d      = 1'b0;
        fail_pulse_d = 1'b0;
        case (state_q)
            ENTRY: begin
                if (entryFull) state_d = CHECK;
            end
            CHECK: begin
                if (codeMatch) begin
                    unlock_d     = 1'b1;
                    match_d      = 1'b1;
                    fail_count_d = '0;
                    timer_d      = UNLOCK_LOAD;
                    state_d      = UNLOCKED;
                end else begin
                    fail_pulse_d = 1'b1;
                    if (fail_count_q < FAIL_LIMIT) fail_count_d = fail_count_q + 4'd1;
                    if (fail_count_d == FAIL_LIMIT) begin
                        alarm_d = 1'b1;
                        timer_d = LOCKOUT_LOAD;
                        state_d = LOCKOUT;
                    end else begin
                        state_d = ENTRY;
                    end
                end
            end
            // The timer was loaded with N-1 on entry, so the output stays high for exactly N cycles.
            UNLOCKED: begin
                if (timer_q == '0) begin
                    unlock_d = 1'b0;
                    state_d  = ENTRY;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    alarm_d      = 1'b0;
                    fail_count_d = '0;
                    state_d      = ENTRY;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    assign unlock      = unlock_q;
    assign alarm       = alarm_q;
    assign fail_count  = fail_count_q;
    assign match_pulse = match_q;
    assign fail_pulse  = fail_pulse_q;

endmodule

// File: tb/tb_passcode_checker.sv
// Self-checking bench for passcode_checker: a scoreboard of expected compare verdicts plus direct timing checks.
module tb_passcode_checker;

    localparam int U  = 4;
    localparam int L  = 8;
    localparam int MF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] code4, code3, code2, code1;
    logic       key_valid, key_clear;
    logic [3:0] key_digit;
    logic       unlock, alarm, match_pulse, fail_pulse;
    logic [2:0] digit_count;
    logic [3:0] fail_count;

    typedef struct packed {
        logic       isMatch;
        logic [3:0] failCnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   n;

    passcode_checker #(.UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L), .MAX_FAIL(MF)) dut (
        .clk         (clk),
        .reset       (reset),
        .code4       (code4),
        .code3       (code3),
        .code2       (code2),
        .code1       (code1),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .key_clear   (key_clear),
        .unlock      (unlock),
        .alarm       (alarm),
        .digit_count (digit_count),
        .fail_count  (fail_count),
        .match_pulse (match_pulse),
        .fail_pulse  (fail_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every compare verdict the DUT reports must match the oldest outstanding attempt.
    always @(negedge clk) begin
        if (!reset && (match_pulse || fail_pulse)) begin
            if (expQ.size() == 0) begin
                checkOutput("sbUnexpectedPulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sbMatchPulse", match_pulse, e.isMatch);
                checkOutput("sbFailPulse", fail_pulse, !e.isMatch);
                checkOutput("sbFailCount", fail_count, e.failCnt);
            end
        end
    end

    task automatic applyStimulus(input logic valid, input logic [3:0] digit, input logic clear);
        key_valid = valid;
        key_digit = digit;
        key_clear = clear;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;
    endtask

    task automatic setCode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        code4 = a; code3 = b; code2 = c; code1 = d;
    endtask

    // Leaves the bench sampling just after the verdict edge (first unlock/alarm cycle).
    task automatic enterCode(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d, input logic expMatch, input logic [3:0] expFail,
                             input bit swapCode);
        expQ.push_back('{isMatch: expMatch, failCnt: expFail});
        applyStimulus(1'b1, a, 1'b0);
        applyStimulus(1'b1, b, 1'b0);
        applyStimulus(1'b1, c, 1'b0);
        applyStimulus(1'b1, d, 1'b0);
        if (swapCode) setCode(4'd9, 4'd9, 4'd9, 4'd9);
        @(posedge clk);
        #1;
    endtask

    task automatic countHigh(input bit selAlarm, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if ((selAlarm ? alarm : unlock) !== 1'b1) break;
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_unlock"}, unlock, 0);
        checkOutput({tag, "_alarm"}, alarm, 0);
        checkOutput({tag, "_digits"}, digit_count, 0);
        checkOutput({tag, "_fails"}, fail_count, 0);
    endtask

    initial begin
        setCode(4'd1, 4'd2, 4'd3, 4'd4);
        key_valid = 1'b0; key_digit = 4'd0; key_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        checkOutput("reset_match", match_pulse, 0);
        checkOutput("reset_failp", fail_pulse, 0);
        reset = 1'b0;

        // Correct code
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 4'(k), 1'b0);
        checkOutput("partialDigits", digit_count, 3);
        applyStimulus(1'b1, 4'd4, 1'b0);
        checkOutput("fullDigits", digit_count, 4);
        expQ.push_back('{isMatch: 1'b1, failCnt: 4'd0});
        @(posedge clk);
        #1;
        checkOutput("okMatchPulse", match_pulse, 1);
        checkOutput("okDigits", digit_count, 0);
        countHigh(1'b0, n);
        checkOutput("unlockLength", n, U);
        checkOutput("okMatchGone", match_pulse, 0);

        // Three wrong attempts into lockout, with keys ignored during lockout
        enterCode(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd1, 1'b0);
        checkOutput("wrong1Fails", fail_count, 1);
        checkOutput("wrong1Alarm", alarm, 0);
        enterCode(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd2, 1'b0);
        checkOutput("wrong2Fails", fail_count, 2);
        enterCode(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd3, 1'b0);
        checkOutput("wrong3Fails", fail_count, 3);
        checkOutput("wrong3Alarm", alarm, 1);
        n = 1;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 4'(k), 1'b0);
            if (alarm === 1'b1) n++;
            checkOutput("lockoutDigits", digit_count, 0);
        end
        @(posedge clk);
        #1;
        begin
            int m;
            countHigh(1'b1, m);
            n += m;
        end
        checkOutput("alarmLength", n, L);
        checkOutput("postLockFails", fail_count, 0);
        checkOutput("postLockUnlock", unlock, 0);

        // Clear wins over a simultaneous key; out-of-range digits ignored
        applyStimulus(1'b1, 4'd1, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b1);
        checkOutput("clearDigits", digit_count, 0);
        applyStimulus(1'b1, 4'hA, 1'b0);
        checkOutput("invalidDigit", digit_count, 0);
        enterCode(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd0, 1'b0);
        checkOutput("clearUnlock", unlock, 1);
        countHigh(1'b0, n);
        checkOutput("clearUnlockLen", n, U);

        // Fail then succeed
        enterCode(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, 4'd1, 1'b0);
        checkOutput("oneFail", fail_count, 1);
        enterCode(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd0, 1'b0);
        checkOutput("recoverUnlock", unlock, 1);
        checkOutput("recoverFails", fail_count, 0);
        countHigh(1'b0, n);

        // Reset during the second unlock cycle
        enterCode(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("unlockCycle2", unlock, 1);
        #2 reset = 1'b1;
        #1;
        checkIdle("rstUnlock");
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset during the third lockout cycle
        enterCode(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd1, 1'b0);
        enterCode(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd2, 1'b0);
        enterCode(4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("lockCycle3", alarm, 1);
        #2 reset = 1'b1;
        #1;
        checkIdle("rstLock");
        @(posedge clk);
        #1 reset = 1'b0;

        // Stored code changes before the compare takes effect
        enterCode(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd1, 1'b1);
        checkOutput("swapFailPulse", fail_pulse, 1);
        checkOutput("swapUnlock", unlock, 0);
        checkOutput("swapFails", fail_count, 1);
        setCode(4'd1, 4'd2, 4'd3, 4'd4);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sbDrained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
